// File: rtl/usb_stream_frame_arbiter.sv
// Round-robin arbiter sharing one USB slave-FIFO write port between two 12-bit
// sample sources; each grant carries exactly FRAME_LEN words closed by a PKTEND strobe.
module usb_stream_frame_arbiter #(
  parameter int unsigned FRAME_LEN = 256,
  parameter int unsigned GAP_CYC   = 4,
  parameter logic [1:0]  FIFO_ADDR = 2'b10,
  localparam int unsigned SAMPLE_W = 12,
  localparam int unsigned FIFO_W   = 16,
  localparam int unsigned CNT_W    = 16,
  localparam int unsigned GAP_W    = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                s0_valid,
  input  logic [SAMPLE_W-1:0] s0_data,
  output logic                s0_ready,
  input  logic                s1_valid,
  input  logic [SAMPLE_W-1:0] s1_data,
  output logic                s1_ready,
  input  logic                flagd,
  output logic [FIFO_W-1:0]   fdata,
  output logic [1:0]          faddr,
  output logic                slwr,
  output logic                pkt_end,
  output logic                sloe,
  output logic                slrd,
  output logic                busy,
  output logic                grant,
  output logic [CNT_W-1:0]    frame_cnt
);

  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(FRAME_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    STREAM,
    EOP,
    GAP
  } state_e;

  state_e                state_q;
  logic [CNT_W-1:0]      word_cnt_q;
  logic [GAP_W-1:0]      gap_cnt_q;
  logic [FIFO_W-1:0]     fdata_q;
  logic [CNT_W-1:0]      frame_cnt_q;
  logic [CNT_W-1:0]      frame_cnt_d;
  logic                  slwr_q;
  logic                  pkt_end_q;
  logic                  busy_q;
  logic                  grant_q;

  logic                  streaming;
  logic                  accept;
  logic                  pick;
  logic [SAMPLE_W-1:0]   sel_data;

  // Only the granted source sees ready, and only while the FIFO has room.
  assign streaming = (state_q == STREAM);
  assign s0_ready  = streaming & ~grant_q & flagd;
  assign s1_ready  = streaming &  grant_q & flagd;
  assign accept    = grant_q ? (s1_valid & s1_ready) : (s0_valid & s0_ready);
  assign sel_data  = grant_q ? s1_data : s0_data;

  // When both request, the channel not served last wins.
  assign pick = (s0_valid & s1_valid) ? ~grant_q : s1_valid;

  assign frame_cnt_d = frame_cnt_q + {{(CNT_W-1){1'b0}}, (state_q == EOP)};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      word_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      fdata_q     <= '0;
      frame_cnt_q <= '0;
      slwr_q      <= 1'b1;
      pkt_end_q   <= 1'b1;
      busy_q      <= 1'b0;
      grant_q     <= 1'b1;
    end else begin
      slwr_q      <= 1'b1;
      pkt_end_q   <= 1'b1;
      frame_cnt_q <= frame_cnt_d;
      unique case (state_q)
        IDLE: begin
          if (enable) state_q <= ARB;
        end
        ARB: begin
          if (!enable) begin
            state_q <= IDLE;
          end else if (s0_valid | s1_valid) begin
            grant_q    <= pick;
            word_cnt_q <= '0;
            busy_q     <= 1'b1;
            state_q    <= STREAM;
          end
        end
        STREAM: begin
          if (accept) begin
            fdata_q    <= {3'b000, grant_q, sel_data};
            slwr_q     <= 1'b0;
            word_cnt_q <= word_cnt_q + CNT_W'(1);
            if (word_cnt_q == LAST_WORD) state_q <= EOP;
          end
        end
        EOP: begin
          pkt_end_q <= 1'b0;
          gap_cnt_q <= '0;
          if (GAP_CYC == 0) begin
            busy_q  <= 1'b0;
            state_q <= ARB;
          end else begin
            state_q <= GAP;
          end
        end
        GAP: begin
          busy_q    <= 1'b0;
          gap_cnt_q <= gap_cnt_q + GAP_W'(1);
          if (gap_cnt_q == GAP_LAST) state_q <= ARB;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fdata     = fdata_q;
  assign slwr      = slwr_q;
  assign pkt_end   = pkt_end_q;
  assign busy      = busy_q;
  assign grant     = grant_q;
  assign frame_cnt = frame_cnt_q;

  // Write-only IN endpoint: address and read controls are tied off.
  assign faddr = FIFO_ADDR;
  assign sloe  = 1'b1;
  assign slrd  = 1'b1;

endmodule
